// File: rtl/alien_formation_scheduler_if.sv
// Kill-request channel between the collision logic and the formation scheduler.
interface alien_formation_scheduler_if;
  logic       kill_valid;
  logic [3:0] kill_idx;
  logic       kill_ready;

  // valid/ready: a kill transfers on every rising clk edge where kill_valid && kill_ready
  // are both high. The master holds kill_valid and kill_idx stable until that edge, and
  // ready never depends on valid.
  modport master (output kill_valid, output kill_idx, input kill_ready);
  modport slave  (input kill_valid, input kill_idx, output kill_ready);
endinterface

// File: rtl/alien_formation_scheduler.sv
// Frame-synchronous owner of enemy positions and alive state. It marches the formation
// sideways every FRAMES_PER_STEP frames, steps down and reverses at a screen edge,
// accepts kills and flags landed / wave-clear conditions.
module alien_formation_scheduler #(
  parameter int NUM_ALIENS      = 10,
  parameter int COLS            = 5,
  parameter int X0              = 70,
  parameter int Y0              = 40,
  parameter int SPACING_X       = 100,
  parameter int SPACING_Y       = 60,
  parameter int SPRITE_W        = 50,
  parameter int SCREEN_W        = 640,
  parameter int STEP_X          = 4,
  parameter int STEP_Y          = 20,
  parameter int FLOOR_Y         = 380,
  parameter int FRAMES_PER_STEP = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       frame_tick,
  input  logic                       enable,
  input  logic                       restart,
  alien_formation_scheduler_if.slave kill,
  output logic [NUM_ALIENS*10-1:0]   alien_x,
  output logic [NUM_ALIENS*9-1:0]    alien_y,
  output logic [NUM_ALIENS-1:0]      alive,
  output logic                       dir,
  output logic                       step_done,
  output logic                       landed,
  output logic                       wave_clear,
  output logic [2:0]                 fsm_state
);

  localparam logic [2:0] S_WAIT   = 3'd0;
  localparam logic [2:0] S_SCAN   = 3'd1;
  localparam logic [2:0] S_DECIDE = 3'd2;
  localparam logic [2:0] S_APPLY  = 3'd3;
  localparam logic [2:0] S_HALT   = 3'd4;

  localparam int CW = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;

  logic [2:0]    state;
  logic [CW-1:0] frame_cnt;
  logic [4:0]    scan_idx;
  logic [9:0]    scan_x;
  logic          scan_live;
  logic [9:0]    samp_x;
  logic          samp_live;
  logic          samp_valid;
  logic [9:0]    min_x;
  logic [9:0]    max_x;
  logic          descend_r;
  logic          right_edge;
  logic          left_edge;
  logic          kill_fire;
  logic          restart_go;
  logic          land_hit;
  logic [NUM_ALIENS-1:0] kill_mask;
  logic [NUM_ALIENS-1:0] alive_after_kill;
  logic [9:0]    x_r   [NUM_ALIENS];
  logic [8:0]    y_r   [NUM_ALIENS];
  logic [8:0]    y_new [NUM_ALIENS];

  function automatic logic [9:0] init_x(input int i);
    return 10'(X0 + (i % COLS) * SPACING_X);
  endfunction

  function automatic logic [8:0] init_y(input int i);
    return 9'(Y0 + (i / COLS) * SPACING_Y);
  endfunction

  assign kill.kill_ready = (state == S_WAIT) || (state == S_HALT);
  assign kill_fire       = kill.kill_valid && kill.kill_ready;
  assign restart_go      = (state == S_HALT) && restart;
  assign fsm_state       = state;

  // Edge tests are done one bit wider than X so the sums cannot wrap.
  assign right_edge = ({1'b0, max_x} + 11'(SPRITE_W) + 11'(STEP_X)) > 11'(SCREEN_W);
  assign left_edge  = {1'b0, min_x} < 11'(STEP_X);

  // Decode the kill index; out-of-range indices produce an empty mask.
  always_comb begin
    kill_mask = '0;
    for (int i = 0; i < NUM_ALIENS; i++)
      if (int'(kill.kill_idx) == i) kill_mask[i] = 1'b1;
    alive_after_kill = kill_fire ? (alive & ~kill_mask) : alive;
  end

  // Select the alien currently addressed by the scan index.
  always_comb begin
    scan_x    = '0;
    scan_live = 1'b0;
    for (int i = 0; i < NUM_ALIENS; i++)
      if (int'(scan_idx) == i) begin
        scan_x    = x_r[i];
        scan_live = alive[i];
      end
  end

  // Candidate Y values for APPLY (saturating at 511) and the landed test on them.
  always_comb begin
    logic [9:0] y_sum;
    y_sum    = '0;
    land_hit = 1'b0;
    for (int i = 0; i < NUM_ALIENS; i++) begin
      y_sum    = {1'b0, y_r[i]} + 10'(STEP_Y);
      y_new[i] = descend_r ? ((y_sum > 10'd511) ? 9'd511 : y_sum[8:0]) : y_r[i];
      if (alive[i] && (({2'b00, y_new[i]} + 11'(SPRITE_W)) >= 11'(FLOOR_Y)))
        land_hit = 1'b1;
    end
  end

  // Pack per-alien registers onto the flat output buses.
  always_comb begin
    alien_x = '0;
    alien_y = '0;
    for (int i = 0; i < NUM_ALIENS; i++) begin
      alien_x[10*i +: 10] = x_r[i];
      alien_y[9*i +: 9]   = y_r[i];
    end
  end

  // Control FSM and frame counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= S_WAIT;
      frame_cnt <= '0;
    end else begin
      case (state)
        S_WAIT: begin
          if (frame_tick && enable) begin
            if (frame_cnt == CW'(FRAMES_PER_STEP - 1)) begin
              frame_cnt <= '0;
              state     <= S_SCAN;
            end else begin
              frame_cnt <= frame_cnt + 1'b1;
            end
          end
        end
        S_SCAN:   if (scan_idx == 5'(NUM_ALIENS)) state <= S_DECIDE;
        S_DECIDE: state <= (alive == '0) ? S_HALT : S_APPLY;
        S_APPLY:  state <= (land_hit || landed) ? S_HALT : S_WAIT;
        S_HALT: begin
          if (restart) begin
            state     <= S_WAIT;
            frame_cnt <= '0;
          end
        end
        default:  state <= S_WAIT;
      endcase
    end
  end

  // Extent scan. The alien mux output is registered before the min/max fold, so the
  // fold lags the index by one cycle and SCAN spends one extra cycle flushing it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      scan_idx   <= '0;
      samp_x     <= '0;
      samp_live  <= 1'b0;
      samp_valid <= 1'b0;
      min_x      <= '1;
      max_x      <= '0;
      descend_r  <= 1'b0;
    end else begin
      if (state == S_WAIT) begin
        scan_idx   <= '0;
        samp_valid <= 1'b0;
        min_x      <= '1;
        max_x      <= '0;
      end else if (state == S_SCAN) begin
        scan_idx   <= scan_idx + 1'b1;
        samp_x     <= scan_x;
        samp_live  <= scan_live;
        samp_valid <= (scan_idx < 5'(NUM_ALIENS));
        if (samp_valid && samp_live) begin
          if (samp_x < min_x) min_x <= samp_x;
          if (samp_x > max_x) max_x <= samp_x;
        end
      end
      if (state == S_DECIDE) descend_r <= dir ? right_edge : left_edge;
    end
  end

  // Formation state: positions, alive mask, direction and status flags.
  always_ff @(posedge clk) begin
    if (!reset || restart_go) begin
      for (int i = 0; i < NUM_ALIENS; i++) begin
        x_r[i] <= init_x(i);
        y_r[i] <= init_y(i);
      end
      alive      <= '1;
      dir        <= 1'b1;
      step_done  <= 1'b0;
      landed     <= 1'b0;
      wave_clear <= 1'b0;
    end else begin
      step_done <= 1'b0;
      if (kill_fire) alive <= alive_after_kill;
      if ((state == S_HALT) && kill_fire && (alive_after_kill == '0)) wave_clear <= 1'b1;
      if ((state == S_DECIDE) && (alive == '0)) wave_clear <= 1'b1;
      if (state == S_APPLY) begin
        for (int i = 0; i < NUM_ALIENS; i++) begin
          if (descend_r) y_r[i] <= y_new[i];
          else           x_r[i] <= dir ? (x_r[i] + 10'(STEP_X)) : (x_r[i] - 10'(STEP_X));
        end
        if (descend_r) dir <= ~dir;
        step_done <= 1'b1;
        if (land_hit) landed <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alien_formation_scheduler.sv
// Directed bench for alien_formation_scheduler: march, edge descend, kill handshake,
// landing (large STEP_Y instance), wave clear, enable freeze and restart.
module tb_alien_formation_scheduler;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic frame_tick = 1'b0;
  logic enable = 1'b1;
  logic restart = 1'b0;

  logic [99:0] alien_x;
  logic [89:0] alien_y;
  logic [9:0]  alive;
  logic        dir, step_done, landed, wave_clear;
  logic [2:0]  fsm_state;

  logic [99:0] l_x;
  logic [89:0] l_y;
  logic [9:0]  l_alive;
  logic        l_dir, l_step_done, l_landed, l_wave_clear;
  logic [2:0]  l_state;

  int checks = 0;
  int failures = 0;
  int sd_count = 0;

  alien_formation_scheduler_if kif ();
  alien_formation_scheduler_if lif ();

  alien_formation_scheduler dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .enable(enable), .restart(restart),
    .kill(kif.slave), .alien_x(alien_x), .alien_y(alien_y), .alive(alive), .dir(dir),
    .step_done(step_done), .landed(landed), .wave_clear(wave_clear), .fsm_state(fsm_state)
  );

  alien_formation_scheduler #(.STEP_Y(240)) dut_land (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .enable(enable), .restart(restart),
    .kill(lif.slave), .alien_x(l_x), .alien_y(l_y), .alive(l_alive), .dir(l_dir),
    .step_done(l_step_done), .landed(l_landed), .wave_clear(l_wave_clear), .fsm_state(l_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  always @(negedge clk) if (step_done) sd_count <= sd_count + 1;

  function automatic int gx(input int i); return int'(alien_x[10*i +: 10]); endfunction
  function automatic int gy(input int i); return int'(alien_y[9*i +: 9]);   endfunction
  function automatic int lx(input int i); return int'(l_x[10*i +: 10]);     endfunction
  function automatic int ly(input int i); return int'(l_y[9*i +: 9]);       endfunction

  // driver tasks
  task automatic do_reset;
    @(negedge clk);
    reset = 1'b0; frame_tick = 1'b0; restart = 1'b0; enable = 1'b1; kif.kill_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic tick;
    @(negedge clk); frame_tick = 1'b1;
    @(negedge clk); frame_tick = 1'b0;
  endtask

  task automatic wait_step(input string name);
    int k;
    k = 0;
    while (!step_done && k < 40) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (!step_done) begin
      failures++;
      $display("FAIL %s step_done timeout got=0 exp=1", name);
    end
  endtask

  task automatic run_steps(input int n, input string name);
    for (int s = 0; s < n; s++) begin
      repeat (8) tick;
      wait_step(name);
    end
  endtask

  task automatic send_kill(input logic [3:0] idx);
    int k;
    @(negedge clk);
    kif.kill_valid = 1'b1;
    kif.kill_idx   = idx;
    k = 0;
    while (!kif.kill_ready && k < 40) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (!kif.kill_ready) begin
      failures++;
      $display("FAIL kill_ready_timeout idx=%0d got=0 exp=1", idx);
    end
    @(negedge clk);
    kif.kill_valid = 1'b0;
  endtask

  task automatic test_reset;
    do_reset;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (gx(i) !== 70 + 100 * (i % 5) || gy(i) !== 40 + 60 * (i / 5)) begin
        failures++;
        $display("FAIL reset_pos alien=%0d got=(%0d,%0d) exp=(%0d,%0d)", i, gx(i), gy(i),
                 70 + 100 * (i % 5), 40 + 60 * (i / 5));
      end
    end
    checks++;
    if ({alive, dir, step_done, landed, wave_clear, kif.kill_ready, fsm_state} !== {10'h3FF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0}) begin
      failures++;
      $display("FAIL reset_flags got alive=%h dir=%b sd=%b ld=%b wc=%b rdy=%b st=%0d exp alive=3ff dir=1 sd=0 ld=0 wc=0 rdy=1 st=0",
               alive, dir, step_done, landed, wave_clear, kif.kill_ready, fsm_state);
    end
  endtask

  task automatic test_first_step;
    int pulse_at, pulses;
    do_reset;
    repeat (7) tick;
    @(negedge clk); frame_tick = 1'b1;
    @(negedge clk); frame_tick = 1'b0;
    pulse_at = 0;
    pulses = 0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (step_done) begin
        pulses++;
        if (pulse_at == 0) pulse_at = k;
      end
    end
    checks++;
    if (pulse_at !== 13 || pulses !== 1) begin
      failures++;
      $display("FAIL first_latency got at=%0d pulses=%0d exp at=13 pulses=1", pulse_at, pulses);
    end
    checks++;
    if (gx(0) !== 74 || gx(4) !== 474 || gy(0) !== 40 || dir !== 1'b1) begin
      failures++;
      $display("FAIL first_move got x0=%0d x4=%0d y0=%0d dir=%b exp x0=74 x4=474 y0=40 dir=1", gx(0), gx(4), gy(0), dir);
    end
  endtask

  task automatic test_march_descend;
    do_reset;
    run_steps(30, "march30");
    checks++;
    if (gx(4) !== 590 || gx(0) !== 190 || dir !== 1'b1) begin
      failures++;
      $display("FAIL march30 got x4=%0d x0=%0d dir=%b exp x4=590 x0=190 dir=1", gx(4), gx(0), dir);
    end
    run_steps(1, "descend_r");
    checks++;
    if (gy(0) !== 60 || gy(5) !== 120 || gx(4) !== 590 || dir !== 1'b0) begin
      failures++;
      $display("FAIL descend_right got y0=%0d y5=%0d x4=%0d dir=%b exp y0=60 y5=120 x4=590 dir=0", gy(0), gy(5), gx(4), dir);
    end
    run_steps(47, "march_left");
    checks++;
    if (gx(0) !== 2 || gy(0) !== 60 || dir !== 1'b0) begin
      failures++;
      $display("FAIL march_left got x0=%0d y0=%0d dir=%b exp x0=2 y0=60 dir=0", gx(0), gy(0), dir);
    end
    run_steps(1, "descend_l");
    checks++;
    if (gy(0) !== 80 || gx(0) !== 2 || dir !== 1'b1) begin
      failures++;
      $display("FAIL descend_left got y0=%0d x0=%0d dir=%b exp y0=80 x0=2 dir=1", gy(0), gx(0), dir);
    end
  endtask

  task automatic test_kill_edge;
    do_reset;
    send_kill(4'd4);
    send_kill(4'd9);
    send_kill(4'd15);
    send_kill(4'd4);
    checks++;
    if (alive !== 10'h1EF) begin
      failures++;
      $display("FAIL kill_mask got=%h exp=1ef", alive);
    end
    run_steps(55, "kill_march");
    checks++;
    if (gx(3) !== 590 || gy(0) !== 40 || dir !== 1'b1) begin
      failures++;
      $display("FAIL kill_march55 got x3=%0d y0=%0d dir=%b exp x3=590 y0=40 dir=1", gx(3), gy(0), dir);
    end
    run_steps(1, "kill_desc");
    checks++;
    if (gx(3) !== 590 || gy(0) !== 60 || dir !== 1'b0) begin
      failures++;
      $display("FAIL kill_descend got x3=%0d y0=%0d dir=%b exp x3=590 y0=60 dir=0", gx(3), gy(0), dir);
    end
  endtask

  task automatic test_kill_during_scan;
    int k;
    do_reset;
    repeat (7) tick;
    @(negedge clk); frame_tick = 1'b1;
    @(negedge clk); frame_tick = 1'b0;
    kif.kill_valid = 1'b1;
    kif.kill_idx   = 4'd2;
    @(negedge clk);
    checks++;
    if (kif.kill_ready !== 1'b0 || fsm_state !== 3'd1) begin
      failures++;
      $display("FAIL scan_ready got rdy=%b st=%0d exp rdy=0 st=1", kif.kill_ready, fsm_state);
    end
    k = 1;
    while (!kif.kill_ready && k < 40) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (k !== 13 || alive[2] !== 1'b1 || step_done !== 1'b1) begin
      failures++;
      $display("FAIL scan_hold got k=%0d alive2=%b sd=%b exp k=13 alive2=1 sd=1", k, alive[2], step_done);
    end
    @(negedge clk);
    kif.kill_valid = 1'b0;
    checks++;
    if (alive !== 10'h3FB) begin
      failures++;
      $display("FAIL scan_accept got=%h exp=3fb", alive);
    end
  endtask

  task automatic test_landed;
    do_reset;
    run_steps(31, "land_steps");
    checks++;
    if (ly(5) !== 340 || ly(0) !== 280 || l_landed !== 1'b1 || l_state !== 3'd4) begin
      failures++;
      $display("FAIL landed got y5=%0d y0=%0d landed=%b st=%0d exp y5=340 y0=280 landed=1 st=4", ly(5), ly(0), l_landed, l_state);
    end
    checks++;
    if (landed !== 1'b0 || gy(5) !== 120) begin
      failures++;
      $display("FAIL not_landed got landed=%b y5=%0d exp landed=0 y5=120", landed, gy(5));
    end
    run_steps(1, "land_more");
    checks++;
    if (lx(4) !== 590 || ly(5) !== 340 || l_state !== 3'd4 || gx(4) !== 586) begin
      failures++;
      $display("FAIL halt_hold got lx4=%0d ly5=%0d st=%0d x4=%0d exp lx4=590 ly5=340 st=4 x4=586", lx(4), ly(5), l_state, gx(4));
    end
    @(negedge clk); restart = 1'b1;
    @(negedge clk); restart = 1'b0;
    checks++;
    if (ly(5) !== 100 || lx(4) !== 470 || l_landed !== 1'b0 || l_alive !== 10'h3FF || l_state !== 3'd0 || l_dir !== 1'b1) begin
      failures++;
      $display("FAIL restart got y5=%0d x4=%0d landed=%b alive=%h st=%0d dir=%b exp y5=100 x4=470 landed=0 alive=3ff st=0 dir=1",
               ly(5), lx(4), l_landed, l_alive, l_state, l_dir);
    end
    checks++;
    if (gx(4) !== 586 || dir !== 1'b0) begin
      failures++;
      $display("FAIL restart_ignored got x4=%0d dir=%b exp x4=586 dir=0", gx(4), dir);
    end
  endtask

  task automatic test_wave_clear;
    int sd0;
    do_reset;
    for (int i = 0; i < 9; i++) send_kill(4'(i));
    repeat (7) tick;
    @(negedge clk); frame_tick = 1'b1; kif.kill_valid = 1'b1; kif.kill_idx = 4'd9;
    @(negedge clk); frame_tick = 1'b0; kif.kill_valid = 1'b0;
    sd0 = sd_count;
    repeat (14) @(negedge clk);
    checks++;
    if (wave_clear !== 1'b1 || fsm_state !== 3'd4 || alive !== 10'h000) begin
      failures++;
      $display("FAIL wave_clear got wc=%b st=%0d alive=%h exp wc=1 st=4 alive=000", wave_clear, fsm_state, alive);
    end
    repeat (8) tick;
    repeat (20) @(negedge clk);
    checks++;
    if (sd_count !== sd0 || gx(0) !== 70 || gy(0) !== 40) begin
      failures++;
      $display("FAIL wave_nomove got steps=%0d x0=%0d y0=%0d exp steps=%0d x0=70 y0=40", sd_count, gx(0), gy(0), sd0);
    end
    @(negedge clk); restart = 1'b1;
    @(negedge clk); restart = 1'b0;
    checks++;
    if (wave_clear !== 1'b0 || alive !== 10'h3FF || fsm_state !== 3'd0) begin
      failures++;
      $display("FAIL wave_restart got wc=%b alive=%h st=%0d exp wc=0 alive=3ff st=0", wave_clear, alive, fsm_state);
    end
  endtask

  task automatic test_enable_freeze;
    int sd0;
    do_reset;
    sd0 = sd_count;
    repeat (3) tick;
    enable = 1'b0;
    repeat (10) tick;
    enable = 1'b1;
    repeat (4) tick;
    repeat (20) @(negedge clk);
    checks++;
    if (sd_count !== sd0 || gx(0) !== 70) begin
      failures++;
      $display("FAIL enable_freeze got steps=%0d x0=%0d exp steps=%0d x0=70", sd_count, gx(0), sd0);
    end
    tick;
    wait_step("enable_resume");
    checks++;
    if (gx(0) !== 74) begin
      failures++;
      $display("FAIL enable_resume got x0=%0d exp=74", gx(0));
    end
  endtask

  initial begin
    kif.kill_valid = 1'b0;
    kif.kill_idx   = 4'd0;
    lif.kill_valid = 1'b0;
    lif.kill_idx   = 4'd0;
    test_reset;
    test_first_step;
    test_march_descend;
    test_kill_edge;
    test_kill_during_scan;
    test_landed;
    test_wave_clear;
    test_enable_freeze;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alien_formation_scheduler.md
Name: alien_formation_scheduler

Overview:
- Frame-synchronous controller that owns the position and alive state of the NUM_ALIENS enemy sprites.
- Its coordinates feed the sprite-compositing VGA controller's per-sprite X/Y inputs.
- Every FRAMES_PER_STEP frames it marches the formation horizontally. At a screen edge it steps the formation down and reverses direction.
- It accepts kill requests from the collision logic through a valid/ready handshake, and flags landed or wave-clear conditions.

Parameters:
NUM_ALIENS, 10, number of enemy sprites (max 16)
COLS, 5, formation columns; alien i sits at col=i%COLS, row=i/COLS
X0, 70, initial X of column 0
Y0, 40, initial Y of row 0
SPACING_X, 100, initial column pitch in pixels
SPACING_Y, 60, initial row pitch in pixels
SPRITE_W, 50, square sprite edge length in pixels
SCREEN_W, 640, visible width
STEP_X, 4, horizontal pixels per march step
STEP_Y, 20, vertical pixels per descend step
FLOOR_Y, 380, landed when a live alien bottom (Y+SPRITE_W) >= FLOOR_Y
FRAMES_PER_STEP, 8, frames between march steps (>=1)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
frame_tick  in  1  one-clk pulse per frame end, already synchronous to clk
enable  in  1  1 = count frames / march; 0 = freeze frame counter
restart  in  1  pulse; honoured only in HALT; re-initialises the formation
kill_valid  in  1  kill request valid
kill_idx  in  4  alien index to kill
kill_ready  out  1  kill accepted on a cycle where kill_valid & kill_ready
alien_x  out  NUM_ALIENS*10  packed X; alien i at [10i+9:10i]
alien_y  out  NUM_ALIENS*9  packed Y; alien i at [9i+8:9i]
alive  out  NUM_ALIENS  alive mask
dir  out  1  1 = moving right, 0 = moving left
step_done  out  1  one-clk pulse when a move/descend has been applied
landed  out  1  sticky; a live alien reached FLOOR_Y
wave_clear  out  1  sticky; all aliens dead

Behaviour:
- Reset (reset==0 at a clk edge):
  - Each alien gets X = X0 + col*SPACING_X and Y = Y0 + row*SPACING_Y.
  - alive = all ones, dir = 1, step_done = 0, landed = 0, wave_clear = 0.
  - Frame counter = 0, state = WAIT, kill_ready = 1.
  - Reset overrides every other input.
- States: WAIT, SCAN, DECIDE, APPLY, HALT.
- WAIT:
  - On frame_tick & enable, the frame counter increments.
  - If the counter equals FRAMES_PER_STEP-1 when the tick arrives, the counter clears and the next state is SCAN.
  - enable=0: ticks are ignored and the counter holds.
- SCAN: NUM_ALIENS cycles, index 0..N-1, one alien per cycle. Accumulates minX and maxX over live aliens only.
- DECIDE, one cycle:
  - If alive == 0: wave_clear <= 1, next state HALT, no move.
  - Else if dir==1 and maxX+SPRITE_W+STEP_X > SCREEN_W: descend.
  - Else if dir==0 and minX < STEP_X: descend.
  - Otherwise: march.
- APPLY, one cycle:
  - March: every alien X += STEP_X (dir=1) or -= STEP_X (dir=0). Y is unchanged.
  - Descend: every alien Y += STEP_Y, X is unchanged, dir toggles.
  - Dead aliens move too, so the formation stays rigid.
  - step_done pulses for the cycle after APPLY, coincident with the updated outputs.
  - Next state is WAIT, or HALT if landed is set.
- Latency: outputs update NUM_ALIENS+3 clk edges after the edge that sampled the qualifying frame_tick.
- Landed check: computed in APPLY on the new Y values, live aliens only. Sets sticky landed.
- Arithmetic:
  - X is 10 bits and Y is 9 bits, unsigned. Edge tests are evaluated in 11 bits so there is no wrap.
  - Y add saturates at 511.
- Kill handshake:
  - kill_ready = 1 in WAIT and HALT, 0 in SCAN/DECIDE/APPLY.
  - On accept, alive[kill_idx] <= 0.
  - Killing an already-dead alien, or kill_idx >= NUM_ALIENS, is accepted with no effect.
  - A kill accepted in the same cycle as a qualifying frame_tick is applied before the SCAN.
- frame_tick outside WAIT is dropped and not counted.
- HALT:
  - Positions hold and ticks are ignored.
  - A kill is still accepted; if it clears the wave, wave_clear sets.
  - restart re-initialises exactly as reset does.
- Reset mid-SCAN/APPLY aborts the step; no partial update is visible.

Test Plan:
- Reset, then 8 frame_ticks with enable=1 -> alien 0 X goes 70->74 and alien 4 X goes 470->474. step_done pulses once, 13 clks after the 8th tick; dir stays 1.
- 30 march steps, then 1 more -> after 30 steps alien 4 X = 590. Step 31 descends: row 0 Y = 60, row 1 Y = 120, X unchanged, dir = 0.
- kill_valid with idx 4 and 9, then march to the edge -> descend triggers on alien 3's column (maxX at 370 start), i.e. after 55 steps, when alien 3 X = 590.
- kill_valid asserted during SCAN -> kill_ready = 0 and not accepted. Held valid, it is accepted in the first WAIT cycle, and alive[idx] clears.
- Override STEP_Y=240, force an edge descend -> row 1 Y = 340 and landed = 1. State is HALT; further ticks do not move, and restart restores initial positions with landed = 0.
- Kill all 10 aliens, then reach a step -> wave_clear = 1, no move, HALT. enable=0 during ticks -> counter frozen and no step_done.
